// File: rtl/valet_retrieval_ctrl.sv
// Valet retrieval controller: pulls one car record from the parking lot FIFO and presents it to the customer.
// Optional statistics outputs are enabled with `define VALET_RETRIEVAL_STATS_EN.
module valet_retrieval_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  retrieve_en,
    input  logic                  fifo_empty,
    input  logic                  fifo_cooldown,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  car_valid,
    output logic [DATA_WIDTH-1:0] car_data,
    input  logic                  car_ready,
    output logic                  unclaimed
`ifdef VALET_RETRIEVAL_STATS_EN
    ,
    output logic [15:0]           delivered_count,
    output logic [15:0]           unclaimed_count
`endif
);

    localparam logic [7:0] WAIT_LOAD = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        LATCH   = 2'd2,
        PRESENT = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       armed;
    logic [7:0] wait_cnt;
    logic       accept;
    logic       timeout;

    assign accept  = (state == PRESENT) && car_ready;
    assign timeout = (state == PRESENT) && !car_ready && (wait_cnt == 8'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // armed holds off the first fetch until one full edge after reset release
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (armed && retrieve_en && !fifo_empty && !fifo_cooldown) state_nxt = FETCH;
            FETCH:   state_nxt = LATCH;
            LATCH:   state_nxt = PRESENT;
            PRESENT: if (accept || timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fifo_rd_en = 1'b0;
        car_valid  = 1'b0;
        case (state)
            FETCH:   fifo_rd_en = 1'b1;
            PRESENT: car_valid  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed     <= 1'b0;
            wait_cnt  <= 8'd0;
            car_data  <= '0;
            unclaimed <= 1'b0;
        end else begin
            armed     <= 1'b1;
            unclaimed <= timeout;
            if (state == LATCH) begin
                car_data <= fifo_data;
                wait_cnt <= WAIT_LOAD;
            end else if ((state == PRESENT) && !accept && (wait_cnt != 8'd0)) begin
                wait_cnt <= wait_cnt - 8'd1;
            end
        end
    end

`ifdef VALET_RETRIEVAL_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            delivered_count <= 16'd0;
            unclaimed_count <= 16'd0;
        end else begin
            if (accept)  delivered_count <= sat_inc(delivered_count);
            if (timeout) unclaimed_count <= sat_inc(unclaimed_count);
        end
    end
`endif

endmodule

// File: tb/tb_valet_retrieval_ctrl.sv
// Self-checking bench for valet_retrieval_ctrl: transaction-level model of each retrieval plus a FIFO model.
// Stats outputs are checked when VALET_RETRIEVAL_STATS_EN is defined.
module tb_valet_retrieval_ctrl;

    localparam int DW = 16;
    localparam int MW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          retrieve_en;
    logic          fifo_empty;
    logic          fifo_cooldown;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data;
    logic          car_valid;
    logic [DW-1:0] car_data;
    logic          car_ready;
    logic          unclaimed;
`ifdef VALET_RETRIEVAL_STATS_EN
    logic [15:0]   delivered_count;
    logic [15:0]   unclaimed_count;
`endif

    int checks = 0;
    int errors = 0;
    int exp_delivered = 0;
    int exp_unclaimed = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];

    valet_retrieval_ctrl #(.DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .retrieve_en(retrieve_en),
        .fifo_empty(fifo_empty),
        .fifo_cooldown(fifo_cooldown),
        .fifo_rd_en(fifo_rd_en),
        .fifo_data(fifo_data),
        .car_valid(car_valid),
        .car_data(car_data),
        .car_ready(car_ready),
        .unclaimed(unclaimed)
`ifdef VALET_RETRIEVAL_STATS_EN
        ,
        .delivered_count(delivered_count),
        .unclaimed_count(unclaimed_count)
`endif
    );

    always #5 clk = ~clk;

    // Registered-output FIFO: data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
            else                   fifo_data <= '0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic perturb(input bit jitter);
        if (jitter) begin
            retrieve_en   = 1'($urandom);
            fifo_empty    = 1'($urandom);
            fifo_cooldown = 1'($urandom);
        end
    endtask

    task automatic settle_idle();
        retrieve_en   = 1'b0;
        fifo_empty    = 1'b1;
        fifo_cooldown = 1'b0;
        car_ready     = 1'b0;
    endtask

    // One retrieval: customer raises ready at presentation index d (never if d > MW)
    task automatic run_car(input logic [DW-1:0] data, input int d, input bit jitter);
        logic [DW-1:0] exp_data;
        bit            seen;
        fifo_q.push_back(data);
        exp_q.push_back(data);
        fifo_empty    = 1'b0;
        fifo_cooldown = 1'b0;
        retrieve_en   = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            if (fifo_rd_en) seen = 1'b1;
        end
        check("rd_en_seen", 32'(seen), 32'd1);
        if (!seen) begin
            settle_idle();
            return;
        end
        perturb(jitter);
        if (!jitter) retrieve_en = 1'b0;
        step();
        check("rd_en_one_cycle", 32'(fifo_rd_en), 32'd0);
        check("valid_not_early", 32'(car_valid), 32'd0);
        perturb(jitter);
        step();
        exp_data = exp_q.pop_front();
        check("valid_after_2", 32'(car_valid), 32'd1);
        check("car_data", 32'(car_data), 32'(exp_data));
        for (int i = 0; i <= MW; i++) begin
            perturb(jitter);
            car_ready = (i == d);
            step();
            if (i == d) begin
                settle_idle();
                exp_delivered++;
                check("accept_drops_valid", 32'(car_valid), 32'd0);
                check("accept_no_unclaimed", 32'(unclaimed), 32'd0);
                break;
            end else if (i == MW) begin
                settle_idle();
                exp_unclaimed++;
                check("timeout_drops_valid", 32'(car_valid), 32'd0);
                check("unclaimed_pulse", 32'(unclaimed), 32'd1);
                step();
                check("unclaimed_one_cycle", 32'(unclaimed), 32'd0);
            end else begin
                check("valid_held", 32'(car_valid), 32'd1);
                check("data_stable", 32'(car_data), 32'(exp_data));
                check("no_early_unclaimed", 32'(unclaimed), 32'd0);
            end
        end
        settle_idle();
    endtask

    initial begin
        reset_n = 1'b0;
        settle_idle();
        fifo_data = '0;
        step();
        step();
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_car_valid", 32'(car_valid), 32'd0);
        check("rst_car_data", 32'(car_data), 32'd0);
        check("rst_unclaimed", 32'(unclaimed), 32'd0);
`ifdef VALET_RETRIEVAL_STATS_EN
        check("rst_delivered", 32'(delivered_count), 32'd0);
        check("rst_unclaimed_cnt", 32'(unclaimed_count), 32'd0);
`endif

        // Release reset with a request already pending; no fetch at the first edge
        retrieve_en = 1'b1;
        fifo_empty  = 1'b0;
        reset_n     = 1'b1;
        step();
        check("no_fetch_first_edge", 32'(fifo_rd_en), 32'd0);

        run_car(16'hA5A5, 0, 1'b0);

        retrieve_en = 1'b1;
        fifo_empty  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("empty_blocks_rd", 32'(fifo_rd_en), 32'd0);
        end
        fifo_empty    = 1'b0;
        fifo_cooldown = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("cooldown_blocks_rd", 32'(fifo_rd_en), 32'd0);
        end
        settle_idle();
        step();

        run_car(16'h1234, MW + 2, 1'b0);
        run_car(16'h5678, MW, 1'b0);
        run_car(16'h0F0F, 1, 1'b0);

        for (int n = 0; n < 16; n++) begin
            run_car(DW'($urandom), int'($urandom_range(0, MW + 2)), 1'b1);
        end

        // Reset while latching: the car is dropped silently
        fifo_q.push_back(16'hBEEF);
        void'(exp_q.size());
        fifo_empty  = 1'b0;
        retrieve_en = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                step();
                if (fifo_rd_en) seen = 1'b1;
            end
            check("rd_en_before_reset", 32'(seen), 32'd1);
        end
        retrieve_en = 1'b0;
        fifo_empty  = 1'b1;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("midrst_car_valid", 32'(car_valid), 32'd0);
        check("midrst_car_data", 32'(car_data), 32'd0);
        check("midrst_unclaimed", 32'(unclaimed), 32'd0);
        exp_delivered = 0;
        exp_unclaimed = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("midrst_no_pulse", 32'(unclaimed), 32'd0);
        end
        reset_n = 1'b1;
        step();
        step();
        check("post_rst_idle", 32'(car_valid), 32'd0);

        run_car(16'h0001, 0, 1'b0);
        run_car(16'h0002, 2, 1'b0);
        run_car(16'h0003, MW + 1, 1'b0);
        run_car(16'h0004, MW, 1'b0);
        run_car(16'h0005, MW + 2, 1'b0);
`ifdef VALET_RETRIEVAL_STATS_EN
        check("delivered_count", 32'(delivered_count), 32'(exp_delivered));
        check("unclaimed_count", 32'(unclaimed_count), 32'(exp_unclaimed));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/valet_retrieval_ctrl.md
VALET_RETRIEVAL_CTRL -- requirements
Module: valet_retrieval_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the car record width and match the upstream parking lot FIFO.
REQ-002 Parameter MAX_WAIT, default 15, range 1..255, SHALL set the customer-accept timeout in cycles.
REQ-003 Timing SHALL be one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous active-low reset.
REQ-006 Port retrieve_en, input, 1: level; permits starting a new retrieval.
REQ-007 Port fifo_empty, input, 1: empty flag from the parking lot FIFO.
REQ-008 Port fifo_cooldown, input, 1: cooldown_active from the parking lot FIFO.
REQ-009 Port fifo_rd_en, output, 1: registered read strobe to the FIFO.
REQ-010 Port fifo_data, input, DATA_WIDTH: registered FIFO data_out, valid one cycle after a read strobe.
REQ-011 Port car_valid, output, 1: car record presented to the customer stage.
REQ-012 Port car_data, output, DATA_WIDTH: presented car record, stable while car_valid=1.
REQ-013 Port car_ready, input, 1: customer accepts when car_valid and car_ready are both 1 at a rising edge.
REQ-014 Port unclaimed, output, 1: one-cycle pulse when a presented car times out.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, LATCH and PRESENT, encoded in 2 bits.
REQ-016 IDLE -> FETCH SHALL occur when retrieve_en=1, fifo_empty=0 and fifo_cooldown=0; otherwise the FSM SHALL stay in IDLE.
REQ-017 fifo_rd_en SHALL be 1 during exactly the single FETCH cycle and 0 in all other states.
REQ-018 FETCH SHALL go unconditionally to LATCH.
REQ-019 LATCH SHALL register fifo_data into car_data, load the wait counter with MAX_WAIT, and go to PRESENT.
REQ-020 In PRESENT, car_valid SHALL be 1, and car_data SHALL hold constant.
REQ-021 In PRESENT, if car_valid&&car_ready, the FSM SHALL go to IDLE with car_valid=0 on the next cycle.
REQ-022 In PRESENT without acceptance, the wait counter SHALL decrement each cycle; when it is 0 and car_ready=0, the block SHALL pulse unclaimed for one cycle, drop the car and go to IDLE.
REQ-023 Acceptance in the same cycle the counter reaches 0 SHALL take priority over timeout, so unclaimed stays 0.
REQ-024 From fifo_rd_en rising to car_valid rising SHALL take exactly 2 cycles; minimum spacing between consecutive retrievals SHALL be 4 cycles.
REQ-025 Changes on retrieve_en, fifo_empty or fifo_cooldown outside IDLE SHALL NOT affect an in-flight retrieval.
REQ-026 The block SHALL NOT assert fifo_rd_en while fifo_empty=1 or fifo_cooldown=1 was sampled in IDLE.

Reset
REQ-027 While reset_n=0, the block SHALL force state=IDLE, fifo_rd_en=0, car_valid=0, car_data=0, unclaimed=0, wait counter=0, and all statistics counters=0.
REQ-028 Reset asserted mid-retrieval, in any state, SHALL abandon the car without an unclaimed pulse.
REQ-029 After reset_n deasserts, the first FETCH SHALL occur no earlier than the second rising edge.

Configuration
REQ-030 With macro VALET_RETRIEVAL_STATS_EN defined, the block SHALL add outputs delivered_count[15:0] and unclaimed_count[15:0].
REQ-031 delivered_count SHALL increment on each acceptance, and unclaimed_count SHALL increment on each unclaimed pulse; both SHALL saturate at 16'hFFFF.
REQ-032 Without VALET_RETRIEVAL_STATS_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Scenario: FIFO holds 16'hA5A5, retrieve_en=1, car_ready=1 -> fifo_rd_en high for 1 cycle, car_valid high 2 cycles later with car_data=16'hA5A5, then IDLE.
REQ-034 Scenario: fifo_empty=1 or fifo_cooldown=1 held for 10 cycles with retrieve_en=1 -> fifo_rd_en remains 0 throughout.
REQ-035 Scenario: MAX_WAIT=3, car_ready=0 -> unclaimed pulses exactly once, 4 cycles after car_valid rises, then car_valid=0.
REQ-036 Scenario: MAX_WAIT=3, car_ready=1 on the final wait cycle -> car accepted and unclaimed stays 0.
REQ-037 Scenario: reset_n pulled low during LATCH -> all outputs 0 immediately, with no unclaimed pulse.
REQ-038 Scenario: with stats enabled, 3 accepted cars and 2 timeouts -> delivered_count=3 and unclaimed_count=2.
